// File: rtl/slice_config_loader.sv
// Assembles one slice configuration frame from WORD_W-bit bitstream words and commits it with a cen pulse.
// Optional checksum word after the frame is enabled by defining CFG_CHECKSUM_EN.
module slice_config_loader #(
  parameter  int S_XX_BASE    = 4,
  parameter  int NUM_LUTS     = 4,
  parameter  int WORD_W       = 8,
  localparam int CFG_SIZE     = 2**S_XX_BASE + 1,
  localparam int MUX_LVLS     = $clog2(NUM_LUTS),
  localparam int LUT_CFG_BITS = 2 * CFG_SIZE * NUM_LUTS,
  localparam int FRAME_BITS   = LUT_CFG_BITS + 1 + MUX_LVLS,
  localparam int NUM_WORDS    = (FRAME_BITS + WORD_W - 1) / WORD_W,
  localparam int CNT_W        = $clog2(NUM_WORDS + 1)
) (
  input  logic                    cclk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  input  logic [WORD_W-1:0]       cfg_word,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [LUT_CFG_BITS-1:0] luts_config_out,
  output logic                    config_use_cc_out,
  output logic [MUX_LVLS-1:0]     inter_lut_mux_config_out,
  output logic                    cen,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // state  | meaning
  // IDLE   | waiting for cfg_start, config outputs hold last committed frame
  // LOAD   | accepting frame words into the shadow register
  // CHECK  | accepting the checksum word (CFG_CHECKSUM_EN builds only)
  // COMMIT | config outputs just loaded, cen high for this single cycle
  // DONE   | done pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CHECK  = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      word_cnt;
  logic [FRAME_BITS-1:0] shadow, shadow_nxt;
  logic                  word_load;
  logic                  last_word;
  logic                  start_frame;

`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0]     csum;
  logic                  check_fail;
  logic                  err_q;
`endif

  assign last_word   = (word_cnt == CNT_W'(NUM_WORDS - 1));
  assign start_frame = (state == S_IDLE) && cfg_start;
  assign word_load   = (state == S_LOAD) && cfg_ready && cfg_valid;
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    cen       = 1'b0;
    done      = 1'b0;
`ifdef CFG_CHECKSUM_EN
    check_fail = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (cfg_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // abort wins over a word presented in the same cycle
        if (cfg_abort) begin
          state_nxt = S_IDLE;
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid && last_word) begin
`ifdef CFG_CHECKSUM_EN
            state_nxt = S_CHECK;
`else
            state_nxt = S_COMMIT;
`endif
          end
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHECK: begin
        if (cfg_abort) begin
          state_nxt = S_IDLE;
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            if (cfg_word == csum) begin
              state_nxt = S_COMMIT;
            end else begin
              state_nxt  = S_IDLE;
              check_fail = 1'b1;
            end
          end
        end
      end
`endif
      S_COMMIT: begin
        cen       = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Padding bits beyond FRAME_BITS in the last word have no home and are dropped.
  always_comb begin
    shadow_nxt = shadow;
    if (word_load) begin
      for (int i = 0; i < FRAME_BITS; i++) begin
        if (word_cnt == CNT_W'(i / WORD_W)) shadow_nxt[i] = cfg_word[i % WORD_W];
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state                    <= S_IDLE;
      word_cnt                 <= '0;
      shadow                   <= '0;
      luts_config_out          <= '0;
      config_use_cc_out        <= 1'b0;
      inter_lut_mux_config_out <= '0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      if (start_frame) begin
        word_cnt <= '0;
      end else if (word_load) begin
        word_cnt <= word_cnt + 1'b1;
      end
      // shadow_nxt already holds the final word when LOAD jumps straight to COMMIT
      if ((state != S_COMMIT) && (state_nxt == S_COMMIT)) begin
        luts_config_out          <= shadow_nxt[LUT_CFG_BITS-1:0];
        config_use_cc_out        <= shadow_nxt[LUT_CFG_BITS];
        inter_lut_mux_config_out <= shadow_nxt[LUT_CFG_BITS+1 +: MUX_LVLS];
      end
    end
  end

`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge cclk) begin
    if (rst) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (start_frame) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (word_load)  csum  <= csum ^ cfg_word;
      if (check_fail) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_slice_config_loader.sv
// Randomized and directed bench for slice_config_loader; expected frames come from a word-level model.
// Builds with or without CFG_CHECKSUM_EN.
module tb_slice_config_loader;
  localparam int WORD_W     = 8;
  localparam int NUM_WORDS  = 18;
  localparam int LUT_BITS   = 136;
  localparam int OUT_BITS   = LUT_BITS + 3;

  logic                cclk = 1'b0;
  logic                rst;
  logic                cfg_start;
  logic                cfg_abort;
  logic [WORD_W-1:0]   cfg_word;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [LUT_BITS-1:0] luts_config_out;
  logic                config_use_cc_out;
  logic [1:0]          inter_lut_mux_config_out;
  logic                cen;
  logic                busy;
  logic                done;
  logic                err;

  int total = 0;
  int bad   = 0;

  logic [WORD_W-1:0]   words [NUM_WORDS];
  logic [LUT_BITS-1:0] exp_luts;
  logic                exp_cc;
  logic [1:0]          exp_mux;

  slice_config_loader dut (
    .cclk                     (cclk),
    .rst                      (rst),
    .cfg_start                (cfg_start),
    .cfg_abort                (cfg_abort),
    .cfg_word                 (cfg_word),
    .cfg_valid                (cfg_valid),
    .cfg_ready                (cfg_ready),
    .luts_config_out          (luts_config_out),
    .config_use_cc_out        (config_use_cc_out),
    .inter_lut_mux_config_out (inter_lut_mux_config_out),
    .cen                      (cen),
    .busy                     (busy),
    .done                     (done),
    .err                      (err)
  );

  always #5 cclk = ~cclk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [OUT_BITS-1:0] obs, input logic [OUT_BITS-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chkw(tag, {inter_lut_mux_config_out, config_use_cc_out, luts_config_out},
              {exp_mux, exp_cc, exp_luts});
  endtask

  // Frame is LSB-first: words 0..16 are the LUT bits, word 17 carries use_cc and the mux bits.
  task automatic model_commit();
    for (int i = 0; i < LUT_BITS / WORD_W; i++) exp_luts[i*WORD_W +: WORD_W] = words[i];
    exp_cc  = words[NUM_WORDS-1][0];
    exp_mux = words[NUM_WORDS-1][2:1];
  endtask

  function automatic logic [WORD_W-1:0] xor_words();
    logic [WORD_W-1:0] x;
    x = '0;
    for (int i = 0; i < NUM_WORDS; i++) x = x ^ words[i];
    return x;
  endfunction

  task automatic next_cycle();
    @(posedge cclk);
    #1;
  endtask

  task automatic start_frame();
    cfg_start = 1'b1;
    cfg_abort = 1'($urandom_range(1));
    @(negedge cclk);
    chk1("idle_ready", cfg_ready, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    next_cycle();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random gaps plus stray cfg_start
  task automatic load_words(input int n, input int gap_mode);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      if (gap_mode == 1 && i > 0) g = 1;
      if (gap_mode == 2) g = $urandom_range(3);
      for (int k = 0; k < g; k++) begin
        cfg_valid = 1'b0;
        cfg_word  = 8'($urandom);
        @(negedge cclk);
        chk1("gap_ready", cfg_ready, 1'b1);
        chk1("gap_cen", cen, 1'b0);
        next_cycle();
      end
      cfg_valid = 1'b1;
      cfg_word  = words[i];
      cfg_start = (gap_mode == 2) ? 1'($urandom_range(1)) : 1'b0;
      @(negedge cclk);
      chk1("ld_ready", cfg_ready, 1'b1);
      chk1("ld_cen", cen, 1'b0);
      chk1("ld_busy", busy, 1'b1);
      chk1("ld_err", err, 1'b0);
      chk_outs("ld_hold");
      next_cycle();
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
  endtask

  task automatic finish_frame(input logic [WORD_W-1:0] check_word, input logic expect_ok);
`ifdef CFG_CHECKSUM_EN
    cfg_valid = 1'b1;
    cfg_word  = check_word;
    @(negedge cclk);
    chk1("chk_ready", cfg_ready, 1'b1);
    chk1("chk_cen", cen, 1'b0);
    next_cycle();
    cfg_valid = 1'b0;
    if (!expect_ok) begin
      @(negedge cclk);
      chk1("bad_err", err, 1'b1);
      chk1("bad_busy", busy, 1'b0);
      chk1("bad_cen", cen, 1'b0);
      chk_outs("bad_hold");
      next_cycle();
      @(negedge cclk);
      chk1("bad_cen2", cen, 1'b0);
      chk1("bad_err2", err, 1'b1);
      next_cycle();
      return;
    end
`else
    if (check_word != 8'h00 && !expect_ok) $display("checksum disabled; frame commits");
`endif
    model_commit();
    cfg_abort = 1'($urandom_range(1));
    @(negedge cclk);
    chk1("cmt_cen", cen, 1'b1);
    chk1("cmt_ready", cfg_ready, 1'b0);
    chk1("cmt_done", done, 1'b0);
    chk1("cmt_err", err, 1'b0);
    chk_outs("cmt_outs");
    next_cycle();
    @(negedge cclk);
    chk1("done_done", done, 1'b1);
    chk1("done_cen", cen, 1'b0);
    chk_outs("done_outs");
    next_cycle();
    cfg_abort = 1'b0;
    @(negedge cclk);
    chk1("post_busy", busy, 1'b0);
    chk1("post_done", done, 1'b0);
    chk1("post_cen", cen, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_word  = '0;
    exp_luts  = '0;
    exp_cc    = 1'b0;
    exp_mux   = 2'b00;

    // reset
    next_cycle();
    next_cycle();
    @(negedge cclk);
    chk1("rst_ready", cfg_ready, 1'b0);
    chk1("rst_cen", cen, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk_outs("rst_outs");
    next_cycle();
    rst = 1'b0;

    // directed frame 0x01..0x12, back-to-back then alternate cycles
    for (int i = 0; i < NUM_WORDS; i++) words[i] = 8'(i + 1);
    for (int pass = 0; pass < 2; pass++) begin
      start_frame();
      load_words(NUM_WORDS, pass);
      finish_frame(8'h13, 1'b1);
      chkw("t2_lut_lo", OUT_BITS'(luts_config_out[7:0]), OUT_BITS'(8'h01));
      chkw("t2_lut_hi", OUT_BITS'(luts_config_out[135:128]), OUT_BITS'(8'h11));
      chk1("t2_cc", config_use_cc_out, 1'b0);
      chkw("t2_mux", OUT_BITS'(inter_lut_mux_config_out), OUT_BITS'(2'b01));
      next_cycle();
    end

`ifdef CFG_CHECKSUM_EN
    // wrong checksum: err set, no commit, next start clears err
    start_frame();
    load_words(NUM_WORDS, 0);
    finish_frame(8'h00, 1'b0);
`endif

    // random frames with random gaps
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NUM_WORDS; i++) words[i] = 8'($urandom);
      start_frame();
      load_words(NUM_WORDS, 2);
      finish_frame(xor_words(), 1'b1);
      next_cycle();
    end

    // abort after 10 words keeps the previous frame
    for (int i = 0; i < NUM_WORDS; i++) words[i] = 8'($urandom);
    start_frame();
    load_words(10, 0);
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_word  = words[10];
    @(negedge cclk);
    chk1("abt_ready", cfg_ready, 1'b0);
    chk1("abt_cen", cen, 1'b0);
    next_cycle();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    @(negedge cclk);
    chk1("abt_busy", busy, 1'b0);
    chk1("abt_cen2", cen, 1'b0);
    chk_outs("abt_hold");
    next_cycle();
    start_frame();
    load_words(NUM_WORDS, 0);
    finish_frame(xor_words(), 1'b1);
    next_cycle();

    // reset after 5 words clears everything
    for (int i = 0; i < NUM_WORDS; i++) words[i] = 8'($urandom);
    start_frame();
    load_words(5, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_luts = '0;
    exp_cc   = 1'b0;
    exp_mux  = 2'b00;
    @(negedge cclk);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_cen", cen, 1'b0);
    chk1("mrst_ready", cfg_ready, 1'b0);
    chk1("mrst_done", done, 1'b0);
    chk_outs("mrst_outs");
    next_cycle();
    start_frame();
    load_words(NUM_WORDS, 1);
    finish_frame(xor_words(), 1'b1);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
